irq_encoder8_3: RTL and testbench

Sequential 8-to-3 interrupt request encoder: the inverse of the 3:8 enabled decoder used for one-hot line selection. It captures rising edges on eight request lines into a pending register, applies a mask, and presents the index of one unmasked pending request as a 3-bit ID. The consumer takes it with a valid/ack handshake. It sits between peripheral interrupt sources and the CPU control unit, which acknowledges an ID before servicing it.

---
 rtl/irq_enc_pkg.sv | 13 +
 rtl/priority_encoder8_3.sv | 25 ++
 rtl/irq_encoder8_3.sv | 93 +++++++++
 tb/tb_irq_encoder8_3.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_enc_pkg.sv
// Shared constants and FSM state type for the 8-to-3 interrupt request encoder.
package irq_enc_pkg;

    localparam int unsigned NUM_IRQ = 8;
    localparam int unsigned ID_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        CLEAR
    } state_t;

endpackage

// File: rtl/priority_encoder8_3.sv
// Combinational 8-to-3 priority encoder: searches downward from start, wrapping 0 -> 7.
module priority_encoder8_3 import irq_enc_pkg::*; (
    input  logic [NUM_IRQ-1:0] vec,
    input  logic [ID_W-1:0]    start,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic [ID_W-1:0] pos;

    // Scan from farthest to nearest so the slot at start is assigned last and wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            pos = start - ID_W'(k);
            if (vec[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder8_3.sv
// Sequential 8-to-3 interrupt encoder with edge capture, mask and valid/ack handshake.
// Define IRQ_ENC_ROUND_ROBIN_EN for round-robin selection instead of fixed priority.
module irq_encoder8_3 import irq_enc_pkg::*; (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] mask,
    input  logic               ack,
    output logic               valid,
    output logic [ID_W-1:0]    id,
    output logic [NUM_IRQ-1:0] pending
);

    logic [NUM_IRQ-1:0] irq_d_q;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] clr_mask;
    logic [NUM_IRQ-1:0] cand;
    state_t             state_q, state_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [ID_W-1:0]    start;
    logic [ID_W-1:0]    enc_idx;
    logic               enc_any;
    logic               ack_take;

    assign cand     = pending_q & mask;
    assign ack_take = (state_q == PRESENT) && ack;
    assign clr_mask = ack_take ? (NUM_IRQ'(1) << id_q) : '0;
    // A new rising edge on the bit being acked keeps it pending.
    assign pending_d = (pending_q & ~clr_mask) | (irq & ~irq_d_q);

`ifdef IRQ_ENC_ROUND_ROBIN_EN
    logic [ID_W-1:0] last_id_q;

    assign start = last_id_q - ID_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_id_q <= '0;
        end else if (ack_take) begin
            last_id_q <= id_q;
        end
    end
`else
    assign start = ID_W'(NUM_IRQ - 1);
`endif

    priority_encoder8_3 u_prio (
        .vec   (cand),
        .start (start),
        .idx   (enc_idx),
        .any   (enc_any)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        case (state_q)
            IDLE, CLEAR: begin
                if (enc_any) begin
                    id_d    = enc_idx;
                    state_d = PRESENT;
                end else begin
                    state_d = IDLE;
                end
            end
            PRESENT: begin
                if (ack) begin
                    state_d = CLEAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_d_q   <= '0;
            pending_q <= '0;
            state_q   <= IDLE;
            id_q      <= '0;
        end else begin
            irq_d_q   <= irq;
            pending_q <= pending_d;
            state_q   <= state_d;
            id_q      <= id_d;
        end
    end

    assign valid   = (state_q == PRESENT);
    assign id      = id_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_irq_encoder8_3.sv
// Self-checking bench for irq_encoder8_3; honours IRQ_ENC_ROUND_ROBIN_EN like the design.
module tb_irq_encoder8_3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] irq = 8'h00;
    logic [7:0] mask = 8'hFF;
    logic       ack = 1'b0;
    logic       valid;
    logic [2:0] id;
    logic [7:0] pending;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: request set, presenting flag, presented id, previous irq, last served.
    logic [7:0] m_pending = 8'h00;
    logic       m_valid   = 1'b0;
    logic [2:0] m_id      = 3'd0;
    logic [7:0] m_prev    = 8'h00;
    logic [2:0] m_last    = 3'd0;

    irq_encoder8_3 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq     (irq),
        .mask    (mask),
        .ack     (ack),
        .valid   (valid),
        .id      (id),
        .pending (pending)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] pick(input logic [7:0] c, input logic [2:0] last);
`ifdef IRQ_ENC_ROUND_ROBIN_EN
        for (int off = 1; off <= 8; off++) begin
            int i;
            i = (int'(last) - off + 8) % 8;
            if (c[i]) return 3'(i);
        end
`else
        for (int i = 7; i >= 0; i--) begin
            if (c[i]) return 3'(i);
        end
`endif
        return 3'd0;
    endfunction

    task automatic model_reset();
        m_pending = 8'h00;
        m_valid   = 1'b0;
        m_id      = 3'd0;
        m_prev    = 8'h00;
        m_last    = 3'd0;
    endtask

    task automatic model_edge();
        logic [7:0] rise;
        rise = irq & ~m_prev;
        if (m_valid) begin
            if (ack) begin
                m_pending[m_id] = 1'b0;
                m_last  = m_id;
                m_valid = 1'b0;
            end
        end else if ((m_pending & mask) != 8'h00) begin
            m_id    = pick(m_pending & mask, m_last);
            m_valid = 1'b1;
        end
        m_pending = m_pending | rise;
        m_prev    = irq;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check_eq("valid", 32'(valid), 32'(m_valid));
        check_eq("id", 32'(id), 32'(m_id));
        check_eq("pending", 32'(pending), 32'(m_pending));
    endtask

    task automatic reset_dut(input logic [7:0] irq_hold);
        reset_n = 1'b0;
        irq     = irq_hold;
        ack     = 1'b0;
        mask    = 8'hFF;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        // Basic single request and ack
        reset_dut(8'h00);
        check_eq("reset_valid", 32'(valid), 32'd0);
        check_eq("reset_pending", 32'(pending), 32'd0);
        irq = 8'h20; tick();
        check_eq("t1_pending", 32'(pending), 32'h20);
        irq = 8'h00; tick();
        check_eq("t1_valid", 32'(valid), 32'd1);
        check_eq("t1_id", 32'(id), 32'd5);
        ack = 1'b1; tick(); ack = 1'b0;
        check_eq("t1_ack_pending", 32'(pending), 32'h00);
        check_eq("t1_ack_valid", 32'(valid), 32'd0);
        tick();
        check_eq("t1_idle_valid", 32'(valid), 32'd0);

        // Two simultaneous requests: 6 then 1, one-cycle gap
        irq = 8'h42; tick();
        irq = 8'h00; tick();
        check_eq("t2_first", 32'(id), 32'd6);
        ack = 1'b1; tick(); ack = 1'b0;
        check_eq("t2_gap", 32'(valid), 32'd0);
        tick();
        check_eq("t2_second_valid", 32'(valid), 32'd1);
        check_eq("t2_second", 32'(id), 32'd1);
        ack = 1'b1; tick(); ack = 1'b0;
        tick();

        // Masked request waits until unmasked
        mask = 8'h00;
        irq = 8'h08; tick();
        irq = 8'h00;
        for (int i = 0; i < 20; i++) tick();
        check_eq("t3_masked_valid", 32'(valid), 32'd0);
        check_eq("t3_masked_pending", 32'(pending), 32'h08);
        mask = 8'h08; tick();
        check_eq("t3_unmask_valid", 32'(valid), 32'd1);
        check_eq("t3_unmask_id", 32'(id), 32'd3);
        ack = 1'b1; tick(); ack = 1'b0;
        mask = 8'hFF; tick();

        // Same-edge set and clear: set wins
        irq = 8'h04; tick();
        irq = 8'h00; tick();
        check_eq("t4_id", 32'(id), 32'd2);
        irq = 8'h04; ack = 1'b1; tick();
        irq = 8'h00; ack = 1'b0;
        check_eq("t4_still_pending", 32'(pending[2]), 32'd1);
        check_eq("t4_clear_valid", 32'(valid), 32'd0);
        tick();
        check_eq("t4_represent_valid", 32'(valid), 32'd1);
        check_eq("t4_represent_id", 32'(id), 32'd2);
        ack = 1'b1; tick(); ack = 1'b0;
        tick();

        // Line held high through reset release, then async reset mid-handshake
        reset_dut(8'h01);
        tick();
        check_eq("t5_pending", 32'(pending), 32'h01);
        tick();
        check_eq("t5_valid", 32'(valid), 32'd1);
        check_eq("t5_id", 32'(id), 32'd0);
        #3 reset_n = 1'b0;
        #1;
        check_eq("t5_async_valid", 32'(valid), 32'd0);
        check_eq("t5_async_id", 32'(id), 32'd0);
        check_eq("t5_async_pending", 32'(pending), 32'd0);
        reset_dut(8'h00);

`ifdef IRQ_ENC_ROUND_ROBIN_EN
        begin
            logic [2:0] exp_order [6];
            exp_order = '{3'd7, 3'd3, 3'd0, 3'd7, 3'd3, 3'd0};
            irq = 8'h89; tick();
            irq = 8'h00;
            for (int g = 0; g < 6; g++) begin
                int budget;
                budget = 10;
                while (!valid && budget > 0) begin
                    tick();
                    budget--;
                end
                if (budget == 0) check_eq("rr_timeout", 32'd0, 32'd1);
                check_eq("rr_order", 32'(id), 32'(exp_order[g]));
                ack = 1'b1;
                irq = 8'(1) << id;
                tick();
                ack = 1'b0;
                irq = 8'h00;
            end
            reset_dut(8'h00);
        end
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            irq = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
            ack = ($urandom_range(0, 3) == 0);
            tick();
        end
        ack = 1'b0;
        irq = 8'h00;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
